// File: rtl/dmem_pkg.sv
// Shared types for the handshaked data memory: access-size encoding, response record, response-register states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dmem_pkg;

    // Encoding of the Size input.
    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    // Widest word the response record can carry; narrower words use the low bits.
    localparam int RESP_MAX_W = 64;

    // Response record captured on the accept edge.
    typedef struct packed {
        logic [RESP_MAX_W-1:0] data;
        logic                  fault;
        logic                  perr;
    } resp_t;

    // Response-register occupancy.
    typedef enum logic {
        RESP_EMPTY = 1'b0,
        RESP_FULL  = 1'b1
    } resp_state_e;

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-wide storage with one independent read/write lane per byte of the word; optional even-parity bit per byte (DMEM_PARITY_EN).
// Latency: writes land on the clock edge; reads are combinational from the array (the top registers them).
// Backpressure: none; the top only asserts a write enable on an accepted, in-range store.
module dmem_byte_array #(
    parameter int DEPTH = 128,
    parameter int PORTS = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                       i_clk,
    input  logic [PORTS-1:0]           i_we,
    input  logic [PORTS-1:0][AW-1:0]   i_addr,
    input  logic [PORTS-1:0][7:0]      i_wdat,
    output logic [PORTS-1:0][7:0]      o_rdat,
    output logic [PORTS-1:0]           o_perr
);

    // Contents are deliberately never reset.
    logic [7:0] r_mem [DEPTH];

    // Byte writes; lanes of one in-range access always target distinct bytes.
    always_ff @(posedge i_clk) begin
        for (int p = 0; p < PORTS; p++) begin
            if (i_we[p]) begin
                r_mem[i_addr[p]] <= i_wdat[p];
            end
        end
    end

    // Combinational read of every lane.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            o_rdat[p] = r_mem[i_addr[p]];
        end
    end

`ifdef DMEM_PARITY_EN
    // Stored bit makes data plus parity carry an even number of ones.
    logic r_par [DEPTH];

    // Parity bit is written alongside its byte.
    always_ff @(posedge i_clk) begin
        for (int p = 0; p < PORTS; p++) begin
            if (i_we[p]) begin
                r_par[i_addr[p]] <= ^i_wdat[p];
            end
        end
    end

    // Per-lane mismatch between stored and recomputed parity.
    always_comb begin
        for (int p = 0; p < PORTS; p++) begin
            o_perr[p] = r_par[i_addr[p]] ^ (^r_mem[i_addr[p]]);
        end
    end
`else
    assign o_perr = '0;
`endif

endmodule

// File: rtl/data_memory_hs.sv
// Byte-addressed big-endian data memory with valid/ready requests and a registered response; optional parity via DMEM_PARITY_EN.
// Latency: request accepted at edge k presents its response after edge k; one access per cycle while the response is consumed.
// Backpressure: ReqReady = !RespValid || RespReady; a stalled response holds data, fault and parity error stable.
module data_memory_hs
    import dmem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 128
) (
    input  logic              i_Clock,
    input  logic              i_Reset_n,
    input  logic              i_ReqValid,
    output logic              o_ReqReady,
    input  logic              i_MemWrite,
    input  logic              i_Size,
    input  logic [ADDR_W-1:0] i_Adresa,
    input  logic [DATA_W-1:0] i_WriteData,
    output logic              o_RespValid,
    input  logic              i_RespReady,
    output logic [DATA_W-1:0] o_ReadData,
    output logic              o_Fault,
    output logic              o_ParityErr
);

    localparam int BYTES = DATA_W / 8;
    localparam int AW    = $clog2(DEPTH);
    // One extra bit so address + length can never wrap.
    localparam int AX    = ADDR_W + 1;

    resp_state_e                 r_state;
    resp_t                       r_resp;
    resp_t                       w_resp_nxt;
    logic                        w_accept;
    logic                        w_is_word;
    logic                        w_fault;
    logic                        w_ld_perr;
    logic [AX-1:0]               w_len;
    logic [AX-1:0]               w_end;
    logic [BYTES-1:0]            w_act;
    logic [BYTES-1:0]            w_we;
    logic [BYTES-1:0]            w_perr;
    logic [BYTES-1:0][AW-1:0]    w_idx;
    logic [BYTES-1:0][7:0]       w_wdat;
    logic [BYTES-1:0][7:0]       w_rdat;
    logic [DATA_W-1:0]           w_rdata;

    assign o_ReqReady = (r_state == RESP_EMPTY) || i_RespReady;
    assign w_accept   = i_ReqValid && o_ReqReady;
    assign w_is_word  = (i_Size == SIZE_WORD);
    assign w_len      = w_is_word ? AX'(BYTES) : AX'(1);
    assign w_end      = {1'b0, i_Adresa} + w_len;
    assign w_fault    = w_end > AX'(DEPTH);

    // Lane steering: lane i holds byte Adresa+i, which is big-endian position i of the word.
    always_comb begin
        w_idx     = '0;
        w_act     = '0;
        w_we      = '0;
        w_wdat    = '0;
        w_rdata   = '0;
        w_ld_perr = 1'b0;
        for (int i = 0; i < BYTES; i++) begin
            w_idx[i]  = AW'({1'b0, i_Adresa} + AX'(i));
            w_act[i]  = w_is_word || (i == 0);
            w_wdat[i] = w_is_word ? i_WriteData[DATA_W-1-8*i -: 8] : i_WriteData[7:0];
            w_we[i]   = w_accept && i_MemWrite && !w_fault && w_act[i];
            if (w_is_word) begin
                w_rdata[DATA_W-1-8*i -: 8] = w_rdat[i];
            end
            if (w_act[i] && w_perr[i]) begin
                w_ld_perr = 1'b1;
            end
        end
        if (!w_is_word) begin
            w_rdata = DATA_W'(w_rdat[0]);
        end
    end

    dmem_byte_array #(
        .DEPTH (DEPTH),
        .PORTS (BYTES)
    ) u_arr (
        .i_clk  (i_Clock),
        .i_we   (w_we),
        .i_addr (w_idx),
        .i_wdat (w_wdat),
        .o_rdat (w_rdat),
        .o_perr (w_perr)
    );

    // Response contents: stores and faults return zero data and no parity error.
    always_comb begin
        w_resp_nxt       = '0;
        w_resp_nxt.fault = w_fault;
        if (!i_MemWrite && !w_fault) begin
            w_resp_nxt.data = RESP_MAX_W'(w_rdata);
            w_resp_nxt.perr = w_ld_perr;
        end
    end

    // Response register: loads on every accept, empties on consume without a new accept.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state <= RESP_EMPTY;
            r_resp  <= '0;
        end else begin
            case (r_state)
                RESP_EMPTY: begin
                    if (w_accept) begin
                        r_state <= RESP_FULL;
                        r_resp  <= w_resp_nxt;
                    end
                end
                RESP_FULL: begin
                    if (w_accept) begin
                        r_resp <= w_resp_nxt;
                    end else if (i_RespReady) begin
                        r_state <= RESP_EMPTY;
                    end
                end
                default: r_state <= RESP_EMPTY;
            endcase
        end
    end

    assign o_RespValid = (r_state == RESP_FULL);
    assign o_ReadData  = DATA_W'(r_resp.data);
    assign o_Fault     = r_resp.fault;
    assign o_ParityErr = r_resp.perr;

endmodule

// File: tb/tb_data_memory_hs.sv
`timescale 1ns/1ps
module tb_data_memory_hs;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 128;
    localparam int BYTES  = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_vld = 1'b0;
    logic              mem_wr = 1'b0;
    logic              size = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              resp_rdy = 1'b0;
    logic              o_ReqReady;
    logic              o_RespValid;
    logic [DATA_W-1:0] o_ReadData;
    logic              o_Fault;
    logic              o_ParityErr;

    always #5 clk = ~clk;

    data_memory_hs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .i_Clock     (clk),
        .i_Reset_n   (rst_n),
        .i_ReqValid  (req_vld),
        .o_ReqReady  (o_ReqReady),
        .i_MemWrite  (mem_wr),
        .i_Size      (size),
        .i_Adresa    (addr),
        .i_WriteData (wdata),
        .o_RespValid (o_RespValid),
        .i_RespReady (resp_rdy),
        .o_ReadData  (o_ReadData),
        .o_Fault     (o_Fault),
        .o_ParityErr (o_ParityErr)
    );

    typedef struct {
        logic [DATA_W-1:0] d;
        logic              f;
        logic              p;
    } exp_t;

    exp_t        q[$];
    byte unsigned mdl [DEPTH];
    bit          bad [DEPTH];
    int          total = 0;
    int          nbad = 0;
    int          rdy_mode = 1;   // 0 random, 1 always ready, 2 never ready

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s act=0x%0h exp=0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        req_vld = 1'b0;
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance with the request still driven.
    task automatic send(input logic we, input logic sz, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] wd, output int waits);
        exp_t e;
        int   n;
        bit   done;
        waits = 0;
        done  = 0;
        mem_wr = we; size = sz; addr = a; wdata = wd; req_vld = 1'b1;
        while (!done) begin
            #1;
            if (o_ReqReady === 1'b1) begin
                done = 1;
            end else if (waits >= 200) begin
                total++; nbad++;
                $display("FAIL req_timeout addr=0x%0h waited=%0d", a, waits);
                req_vld = 1'b0;
                return;
            end else begin
                waits++;
                @(negedge clk);
            end
        end
        n   = sz ? BYTES : 1;
        e.f = (int'(a) + n) > DEPTH;
        e.d = '0;
        e.p = 1'b0;
        if (!e.f) begin
            for (int i = 0; i < n; i++) begin
                int ix;
                ix = int'(a) + i;
                if (we) begin
                    mdl[ix] = sz ? 8'(wd >> (8 * (BYTES - 1 - i))) : wd[7:0];
                    bad[ix] = 0;
                end else begin
                    e.d = (e.d << 8) | DATA_W'(mdl[ix]);
                    if (bad[ix]) e.p = 1'b1;
                end
            end
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    // Response monitor: drives RespReady, pops and compares consumed responses, checks stall stability.
    initial begin : mon
        exp_t              e;
        logic [DATA_W-1:0] pd;
        logic              pf, pp;
        bit                have_prev;
        have_prev = 0;
        pd = '0; pf = 1'b0; pp = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       resp_rdy = ($urandom_range(0, 3) != 0);
                1:       resp_rdy = 1'b1;
                default: resp_rdy = 1'b0;
            endcase
            #2;
            if (rst_n) begin
                total++;
                if (o_ReqReady !== (!o_RespValid || resp_rdy)) begin
                    nbad++;
                    $display("FAIL req_ready act=%0b exp=%0b", o_ReqReady, (!o_RespValid || resp_rdy));
                end
                if (have_prev && o_RespValid) begin
                    total++;
                    if ({o_ReadData, o_Fault, o_ParityErr} !== {pd, pf, pp}) begin
                        nbad++;
                        $display("FAIL hold_stable act=%h/%b/%b exp=%h/%b/%b",
                                 o_ReadData, o_Fault, o_ParityErr, pd, pf, pp);
                    end
                end
                if (o_RespValid && resp_rdy) begin
                    total++;
                    if (q.size() == 0) begin
                        nbad++;
                        $display("FAIL unexpected_resp act=%h/%b/%b exp=none", o_ReadData, o_Fault, o_ParityErr);
                    end else begin
                        e = q.pop_front();
                        if ({o_ReadData, o_Fault, o_ParityErr} !== {e.d, e.f, e.p}) begin
                            nbad++;
                            $display("FAIL resp act=%h/%b/%b exp=%h/%b/%b",
                                     o_ReadData, o_Fault, o_ParityErr, e.d, e.f, e.p);
                        end
                    end
                end
                have_prev = o_RespValid && !resp_rdy;
                pd = o_ReadData; pf = o_Fault; pp = o_ParityErr;
            end else begin
                have_prev = 0;
            end
        end
    end

    initial begin : main
        int  w;
        int  r;
        logic [ADDR_W-1:0] a;
        bit  drained;

        // Reset state
        #12;
        chk("rst_resp_valid", 32'(o_RespValid), 32'd0);
        chk("rst_read_data",  32'(o_ReadData),  32'd0);
        chk("rst_fault",      32'(o_Fault),     32'd0);
        chk("rst_parity",     32'(o_ParityErr), 32'd0);
        chk("rst_req_ready",  32'(o_ReqReady),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Give every byte a known value, back to back.
        for (int i = 0; i < DEPTH; i += BYTES) begin
            send(1'b1, 1'b1, ADDR_W'(i), DATA_W'($urandom), w);
        end

        // Word store then word and byte load.
        send(1'b1, 1'b1, 16'd4, 16'hBEEF, w);
        send(1'b0, 1'b1, 16'd4, 16'h0000, w);
        send(1'b0, 1'b0, 16'd5, 16'h0000, w);

        // Unaligned word.
        send(1'b1, 1'b1, 16'd7, 16'h1234, w);
        send(1'b0, 1'b1, 16'd6, 16'h0000, w);
        send(1'b0, 1'b0, 16'd8, 16'h0000, w);

        // Range faults at the top of memory and at the top of the address space.
        send(1'b0, 1'b1, 16'd127, 16'h0000, w);
        send(1'b1, 1'b1, 16'd127, 16'hA5A5, w);
        send(1'b0, 1'b0, 16'd127, 16'h0000, w);
        send(1'b0, 1'b0, 16'd128, 16'h0000, w);
        send(1'b0, 1'b1, 16'd126, 16'h0000, w);
        send(1'b1, 1'b1, 16'hFFFF, 16'h5555, w);

        // Parity: corrupt byte 10 when parity storage exists.
        idle();
`ifdef DMEM_PARITY_EN
        dut.u_arr.r_par[10] = ~dut.u_arr.r_par[10];
        bad[10] = 1;
`endif
        @(negedge clk);
        send(1'b0, 1'b0, 16'd10, 16'h0000, w);
        send(1'b0, 1'b1, 16'd9,  16'h0000, w);
        send(1'b0, 1'b1, 16'd11, 16'h0000, w);

        // Back-pressure: stall a response for three cycles with a request waiting.
        idle();
        #1 rdy_mode = 2;
        @(negedge clk);
        send(1'b0, 1'b1, 16'd4, 16'h0000, w);
        mem_wr = 1'b0; size = 1'b0; addr = 16'd5; req_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_req_ready", 32'(o_ReqReady), 32'd0);
            chk("stall_resp_valid", 32'(o_RespValid), 32'd1);
            if (k == 2) rdy_mode = 1;
            @(negedge clk);
        end
        send(1'b0, 1'b0, 16'd5, 16'h0000, w);
        chk("b2b_accept_waits", 32'(w), 32'd0);

        // Reset while a response is pending.
        idle();
        #1 rdy_mode = 2;
        @(negedge clk);
        send(1'b0, 1'b1, 16'd4, 16'h0000, w);
        idle();
        #3;
        chk("pre_rst_valid", 32'(o_RespValid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(o_RespValid), 32'd0);
        chk("mid_rst_data",  32'(o_ReadData),  32'd0);
        chk("mid_rst_fault", 32'(o_Fault),     32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(o_ReqReady), 32'd1);
        rdy_mode = 1;
        @(negedge clk);
        // Stores made before reset survive it.
        send(1'b0, 1'b1, 16'd4, 16'h0000, w);
        send(1'b0, 1'b1, 16'd7, 16'h0000, w);

        // Randomized traffic with random response back-pressure.
        idle();
        #1 rdy_mode = 0;
        @(negedge clk);
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            a = (r == 0) ? ADDR_W'(16'hFFFF - $urandom_range(0, 2)) : ADDR_W'($urandom_range(0, DEPTH + 1));
            send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, DATA_W'($urandom), w);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(negedge clk);
            end
        end

        // Drain outstanding responses.
        idle();
        #1 rdy_mode = 1;
        drained = 0;
        for (int c = 0; c < 100 && !drained; c++) begin
            @(negedge clk);
            #3;
            if (q.size() == 0 && o_RespValid === 1'b0) drained = 1;
        end
        chk("drain_queue_left", 32'(q.size()), 32'd0);
        chk("drain_resp_valid", 32'(o_RespValid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, nbad);
        $finish;
    end

endmodule
